// File: rtl/scope_capture_ctrl.sv
// ---------------------------------------------------------------------------
// scope_capture_ctrl
//
// Capture sequencer for one oscilloscope channel. Enables the ADC channel,
// fills a circular sample buffer with a pre-trigger history, waits for a
// level/slope trigger (or an auto-mode timeout), records the post-trigger
// part of the frame and then holds the frame for the display reader until
// it is acknowledged.
//
// Ports:
//   clock, rst_n        system clock, asynchronous active-low reset
//   sample_in           signed sample from the channel block
//   sample_valid        one-cycle strobe qualifying sample_in/out_of_range
//   out_of_range        front-end overrange flag
//   arm                 start capture (level, honoured in IDLE only)
//   abort               return to IDLE, highest priority
//   mode                0 normal, 1 auto, 2 single, 3 normal
//   trig_slope          0 rising, 1 falling
//   trig_level          signed trigger threshold
//   pretrig             samples kept before the trigger
//   done_ack            reader has finished with the frame
//   adc_en              channel enable to the front-end
//   mem_we/waddr/wdata  sample RAM write port
//   frame_start         address of the oldest sample of the completed frame
//   done                frame complete, held until done_ack
//   trig_auto           frame was force-triggered by the auto timeout
//   ovr_flag            sticky overrange seen during the frame
//   busy                controller is not idle
// ---------------------------------------------------------------------------
module scope_capture_ctrl #(
   parameter int DATA_W       = 14,
   parameter int ADDR_W       = 10,
   parameter int AUTO_TIMEOUT = 1048576
) (
   input  logic                     clock,
   input  logic                     rst_n,
   input  logic signed [DATA_W-1:0] sample_in,
   input  logic                     sample_valid,
   input  logic                     out_of_range,
   input  logic                     arm,
   input  logic                     abort,
   input  logic [1:0]               mode,
   input  logic                     trig_slope,
   input  logic signed [DATA_W-1:0] trig_level,
   input  logic [ADDR_W-1:0]        pretrig,
   input  logic                     done_ack,
   output logic                     adc_en,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_waddr,
   output logic [DATA_W-1:0]        mem_wdata,
   output logic [ADDR_W-1:0]        frame_start,
   output logic                     done,
   output logic                     trig_auto,
   output logic                     ovr_flag,
   output logic                     busy
);

   localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
   localparam logic [TO_W-1:0]   TO_MAX = TO_W'(AUTO_TIMEOUT);
   localparam logic [TO_W-1:0]   ONE_T  = 1;
   localparam logic [ADDR_W-1:0] ONE_A  = 1;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PRE  = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_POST = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]               state_q, state_d;
   logic [ADDR_W-1:0]        waddr_q, waddr_d;
   logic [ADDR_W-1:0]        pcnt_q, pcnt_d;
   logic [ADDR_W-1:0]        p_q, p_d;
   logic [ADDR_W-1:0]        remaining_q, remaining_d;
   logic [ADDR_W-1:0]        frame_start_q, frame_start_d;
   logic [ADDR_W-1:0]        mem_waddr_q, mem_waddr_d;
   logic [DATA_W-1:0]        mem_wdata_q, mem_wdata_d;
   logic signed [DATA_W-1:0] prev_q, prev_d;
   logic                     prev_valid_q, prev_valid_d;
   logic                     ovr_q, ovr_d;
   logic                     trig_auto_q, trig_auto_d;
   logic                     mem_we_q, mem_we_d;
   logic                     adc_en_q, adc_en_d;
   logic                     done_q, done_d;
   logic [TO_W-1:0]          tcnt_q, tcnt_d;

   logic                     capturing;
   logic                     wr_en;
   logic                     real_trig;
   logic                     force_trig;
   logic                     start;
   logic [ADDR_W-1:0]        start_p;

   assign capturing = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
   assign wr_en     = capturing && sample_valid && !abort;

   // Slope detection needs a previous sample from the current capture.
   assign real_trig = sample_valid && prev_valid_q &&
                      (trig_slope ? ((prev_q > trig_level) && (sample_in <= trig_level))
                                  : ((prev_q < trig_level) && (sample_in >= trig_level)));

   // Counter saturates at the timeout, so the first valid sample from then on is forced.
   assign force_trig = sample_valid && (mode == 2'd1) && (tcnt_q == TO_MAX);

   always_comb begin
      state_d       = state_q;
      waddr_d       = waddr_q;
      pcnt_d        = pcnt_q;
      p_d           = p_q;
      remaining_d   = remaining_q;
      frame_start_d = frame_start_q;
      mem_waddr_d   = mem_waddr_q;
      mem_wdata_d   = mem_wdata_q;
      prev_d        = prev_q;
      prev_valid_d  = prev_valid_q;
      ovr_d         = ovr_q;
      trig_auto_d   = trig_auto_q;
      tcnt_d        = tcnt_q;
      mem_we_d      = 1'b0;
      adc_en_d      = capturing;
      start         = 1'b0;
      start_p       = p_q;

      if (wr_en) begin
         mem_we_d    = 1'b1;
         mem_waddr_d = waddr_q;
         mem_wdata_d = sample_in;
         waddr_d     = waddr_q + ONE_A;
         if (out_of_range) begin
            ovr_d = 1'b1;
         end
      end

      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (arm) begin
                  start   = 1'b1;
                  start_p = pretrig;
               end
            end
            S_PRE: begin
               if (sample_valid) begin
                  prev_d       = sample_in;
                  prev_valid_d = 1'b1;
                  pcnt_d       = pcnt_q + ONE_A;
                  if (pcnt_q + ONE_A == p_q) begin
                     state_d = S_WAIT;
                     tcnt_d  = '0;
                  end
               end
            end
            S_WAIT: begin
               if (tcnt_q != TO_MAX) begin
                  tcnt_d = tcnt_q + ONE_T;
               end
               if (sample_valid) begin
                  prev_d       = sample_in;
                  prev_valid_d = 1'b1;
               end
               if (real_trig || force_trig) begin
                  frame_start_d = waddr_q - p_q;
                  trig_auto_d   = force_trig && !real_trig;
                  // DEPTH-1-P post samples; bitwise inverse of P in ADDR_W bits.
                  remaining_d   = ~p_q;
                  state_d       = (p_q == '1) ? S_DONE : S_POST;
               end
            end
            S_POST: begin
               if (sample_valid) begin
                  remaining_d = remaining_q - ONE_A;
                  if (remaining_q == ONE_A) begin
                     state_d = S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (done_ack && (mode != 2'd2)) begin
                  start = 1'b1;
               end else if (done_ack) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase

         // Common entry actions for a fresh capture (arm from IDLE or re-arm from DONE).
         if (start) begin
            p_d          = start_p;
            waddr_d      = '0;
            pcnt_d       = '0;
            prev_valid_d = 1'b0;
            ovr_d        = 1'b0;
            trig_auto_d  = 1'b0;
            tcnt_d       = '0;
            state_d      = (start_p == '0) ? S_WAIT : S_PRE;
         end
      end

      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         waddr_q       <= '0;
         pcnt_q        <= '0;
         p_q           <= '0;
         remaining_q   <= '0;
         frame_start_q <= '0;
         mem_waddr_q   <= '0;
         mem_wdata_q   <= '0;
         prev_q        <= '0;
         prev_valid_q  <= 1'b0;
         ovr_q         <= 1'b0;
         trig_auto_q   <= 1'b0;
         tcnt_q        <= '0;
         mem_we_q      <= 1'b0;
         adc_en_q      <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         waddr_q       <= waddr_d;
         pcnt_q        <= pcnt_d;
         p_q           <= p_d;
         remaining_q   <= remaining_d;
         frame_start_q <= frame_start_d;
         mem_waddr_q   <= mem_waddr_d;
         mem_wdata_q   <= mem_wdata_d;
         prev_q        <= prev_d;
         prev_valid_q  <= prev_valid_d;
         ovr_q         <= ovr_d;
         trig_auto_q   <= trig_auto_d;
         tcnt_q        <= tcnt_d;
         mem_we_q      <= mem_we_d;
         adc_en_q      <= adc_en_d;
         done_q        <= done_d;
      end
   end

   assign adc_en      = adc_en_q;
   assign mem_we      = mem_we_q;
   assign mem_waddr   = mem_waddr_q;
   assign mem_wdata   = mem_wdata_q;
   assign frame_start = frame_start_q;
   assign done        = done_q;
   assign trig_auto   = trig_auto_q;
   assign ovr_flag    = ovr_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// ---------------------------------------------------------------------------
// Directed testbench for scope_capture_ctrl (DEPTH=16, AUTO_TIMEOUT=50).
// A behavioural RAM captures the write port; expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_scope_capture_ctrl;

   localparam int DW = 14;
   localparam int AW = 4;
   localparam int TO = 50;

   logic                 clock = 1'b0;
   logic                 rst_n;
   logic signed [DW-1:0] sample_in;
   logic                 sample_valid;
   logic                 out_of_range;
   logic                 arm;
   logic                 abort;
   logic [1:0]           mode;
   logic                 trig_slope;
   logic signed [DW-1:0] trig_level;
   logic [AW-1:0]        pretrig;
   logic                 done_ack;
   logic                 adc_en;
   logic                 mem_we;
   logic [AW-1:0]        mem_waddr;
   logic [DW-1:0]        mem_wdata;
   logic [AW-1:0]        frame_start;
   logic                 done;
   logic                 trig_auto;
   logic                 ovr_flag;
   logic                 busy;

   int checks = 0;
   int errors = 0;
   int we_cnt = 0;
   int base;
   logic signed [DW-1:0] ram [16];

   always #5 clock = ~clock;

   scope_capture_ctrl #(.DATA_W(DW), .ADDR_W(AW), .AUTO_TIMEOUT(TO)) dut (
      .clock(clock), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
      .out_of_range(out_of_range), .arm(arm), .abort(abort), .mode(mode),
      .trig_slope(trig_slope), .trig_level(trig_level), .pretrig(pretrig),
      .done_ack(done_ack), .adc_en(adc_en), .mem_we(mem_we), .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata), .frame_start(frame_start), .done(done),
      .trig_auto(trig_auto), .ovr_flag(ovr_flag), .busy(busy)
   );

   always @(posedge clock) begin
      if (mem_we) begin
         ram[mem_waddr] <= mem_wdata;
         we_cnt         <= we_cnt + 1;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic feed(input int v, input logic oor);
      sample_in    = v[DW-1:0];
      sample_valid = 1'b1;
      out_of_range = oor;
      tick();
   endtask

   task automatic idle();
      sample_valid = 1'b0;
      out_of_range = 1'b0;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; sample_in = '0; sample_valid = 1'b0; out_of_range = 1'b0;
      arm = 1'b0; abort = 1'b0; mode = 2'd0; trig_slope = 1'b0; trig_level = '0;
      pretrig = '0; done_ack = 1'b0;
      repeat (2) tick();
      check("rst_adc_en", adc_en, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_waddr", mem_waddr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_frame_start", frame_start, 0);
      check("rst_done", done, 0);
      check("rst_trig_auto", trig_auto, 0);
      check("rst_ovr_flag", ovr_flag, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      tick();

      // Normal mode, P=4, rising through 0 on a ramp; overrange on sample 5.
      pretrig = 4; mode = 2'd0; trig_slope = 1'b0; trig_level = 0;
      arm = 1'b1; tick(); arm = 1'b0;
      check("t1_busy_after_arm", busy, 1);
      base = we_cnt;
      for (int s = -20; s <= 20; s++) feed(s, s == 5);
      idle();
      check("t1_done", done, 1);
      check("t1_frame_start", frame_start, 0);
      check("t1_trig_auto", trig_auto, 0);
      check("t1_ovr_flag", ovr_flag, 1);
      check("t1_adc_en_off", adc_en, 0);
      check("t1_writes", we_cnt - base, 32);
      for (int i = 0; i < 16; i++) check($sformatf("t1_ram%0d", i), ram[i], i - 4);
      $display("txn t1 ramp frame checked");

      // Re-arm in normal mode clears the sticky flag.
      done_ack = 1'b1; tick(); done_ack = 1'b0;
      check("t1_ack_done", done, 0);
      check("t1_ack_busy", busy, 1);
      check("t1_ack_ovr_clear", ovr_flag, 0);
      tick();
      check("t1_rearm_adc_en", adc_en, 1);
      $display("txn t1 re-arm checked");

      // Falling slope at 100; constant 100 must not trigger.
      trig_slope = 1'b1; trig_level = 100;
      base = we_cnt;
      repeat (30) feed(100, 1'b0);
      idle();
      check("t2_no_trig_done", done, 0);
      check("t2_const_writes", we_cnt - base, 30);
      feed(350, 1'b0); feed(500, 1'b0); feed(350, 1'b0); feed(0, 1'b0);
      repeat (13) feed(-400, 1'b0);
      idle();
      check("t2_done", done, 1);
      check("t2_frame_start", frame_start, 13);
      check("t2_trig_auto", trig_auto, 0);
      check("t2_writes", we_cnt - base, 45);
      check("t2_ram13", ram[13], 100);
      check("t2_ram14", ram[14], 350);
      check("t2_ram15", ram[15], 500);
      check("t2_ram0", ram[0], 350);
      check("t2_ram1", ram[1], 0);
      check("t2_ram2", ram[2], -400);
      check("t2_ram12", ram[12], -400);
      $display("txn t2 falling frame checked");

      // Single mode: acknowledge returns to IDLE.
      mode = 2'd2;
      done_ack = 1'b1; tick(); done_ack = 1'b0;
      check("t2_single_busy", busy, 0);
      check("t2_single_done", done, 0);
      check("t2_single_fs_hold", frame_start, 13);
      tick();
      check("t2_single_adc_en", adc_en, 0);
      $display("txn t2 single-mode ack checked");

      // P=0: first WAIT sample has no predecessor and cannot trigger.
      mode = 2'd0; trig_slope = 1'b0; trig_level = 3; pretrig = 0;
      arm = 1'b1; tick(); arm = 1'b0;
      base = we_cnt;
      feed(5, 1'b0); feed(6, 1'b0); feed(-5, 1'b0); feed(5, 1'b0);
      repeat (15) feed(7, 1'b0);
      idle();
      check("t3_done", done, 1);
      check("t3_frame_start", frame_start, 3);
      check("t3_writes", we_cnt - base, 19);
      abort = 1'b1; tick(); abort = 1'b0;
      check("t3_abort_busy", busy, 0);
      check("t3_abort_done", done, 0);
      $display("txn t3 P=0 frame checked");

      // Auto mode forces a trigger on the 51st WAIT sample.
      mode = 2'd1; trig_level = 1000;
      arm = 1'b1; tick(); arm = 1'b0;
      base = we_cnt;
      repeat (66) feed(0, 1'b0);
      idle();
      check("t4_done", done, 1);
      check("t4_trig_auto", trig_auto, 1);
      check("t4_frame_start", frame_start, 2);
      check("t4_writes", we_cnt - base, 66);
      abort = 1'b1; tick(); abort = 1'b0;
      $display("txn t4 auto frame checked");

      // P=15: DONE directly after the trigger write.
      mode = 2'd0; trig_level = 0; pretrig = 15;
      arm = 1'b1; tick(); arm = 1'b0;
      for (int s = -15; s <= -1; s++) feed(s, 1'b0);
      feed(0, 1'b0);
      check("t5_done", done, 1);
      check("t5_trig_we", mem_we, 1);
      check("t5_trig_waddr", mem_waddr, 15);
      check("t5_trig_wdata", mem_wdata, 0);
      check("t5_frame_start", frame_start, 0);
      check("t5_trig_auto_clr", trig_auto, 0);
      feed(1, 1'b0);
      check("t5_no_more_we", mem_we, 0);
      idle();
      abort = 1'b1; tick(); abort = 1'b0;
      $display("txn t5 P=15 frame checked");

      // Abort during POST with a valid sample in the same cycle.
      pretrig = 4;
      arm = 1'b1; tick(); arm = 1'b0;
      base = we_cnt;
      for (int s = -4; s <= 3; s++) feed(s, 1'b0);
      sample_in = 4; sample_valid = 1'b1; abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t6_abort_busy", busy, 0);
      check("t6_abort_we", mem_we, 0);
      check("t6_abort_done", done, 0);
      feed(5, 1'b0); feed(6, 1'b0);
      idle();
      check("t6_writes", we_cnt - base, 8);
      check("t6_adc_en", adc_en, 0);
      check("t6_we_idle", mem_we, 0);
      $display("txn t6 abort checked");

      // Asynchronous reset mid-capture.
      arm = 1'b1; tick(); arm = 1'b0;
      feed(1, 1'b1); feed(2, 1'b0);
      sample_in = 3; sample_valid = 1'b1; tick();
      check("t7_pre_we", mem_we, 1);
      check("t7_pre_waddr", mem_waddr, 2);
      check("t7_pre_wdata", mem_wdata, 3);
      check("t7_pre_ovr", ovr_flag, 1);
      check("t7_pre_adc_en", adc_en, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t7_rst_we", mem_we, 0);
      check("t7_rst_waddr", mem_waddr, 0);
      check("t7_rst_wdata", mem_wdata, 0);
      check("t7_rst_ovr", ovr_flag, 0);
      check("t7_rst_adc_en", adc_en, 0);
      check("t7_rst_busy", busy, 0);
      check("t7_rst_done", done, 0);
      check("t7_rst_fs", frame_start, 0);
      check("t7_rst_trig_auto", trig_auto, 0);
      sample_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      $display("txn t7 async reset checked");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/scope_capture_ctrl.md
# scope_capture_ctrl

Capture sequencer for one oscilloscope channel. Sits between the ADC front-end channel block and the sample RAM. Enables the channel, detects a level/slope trigger on the incoming 14-bit samples, and writes a pre/post-trigger frame into a circular buffer. It then hands the frame to the display reader with a done/ack handshake.

## Interface
Parameters:
- DATA_W, 14, sample width (two's complement, ±8192 levels)
- ADDR_W, 10, buffer address width; DEPTH = 2^ADDR_W
- AUTO_TIMEOUT, 1048576, clock cycles without trigger before auto-mode forces one

Ports:
- clock  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- sample_in  in  DATA_W  signed sample from channel block
- sample_valid  in  1  one-cycle strobe, sample_in valid
- out_of_range  in  1  front-end overrange, qualified by sample_valid
- arm  in  1  start capture (level, sampled in IDLE only)
- abort  in  1  return to IDLE
- mode  in  2  0 normal, 1 auto, 2 single, 3 treated as normal
- trig_slope  in  1  0 rising, 1 falling
- trig_level  in  DATA_W  signed trigger threshold
- pretrig  in  ADDR_W  samples kept before trigger
- done_ack  in  1  reader finished with frame
- adc_en  out  1  channel enable to front-end
- mem_we  out  1  RAM write strobe
- mem_waddr  out  ADDR_W  RAM write address
- mem_wdata  out  DATA_W  RAM write data
- frame_start  out  ADDR_W  address of oldest sample in completed frame
- done  out  1  frame complete, held until done_ack
- trig_auto  out  1  frame was force-triggered by timeout
- ovr_flag  out  1  sticky: any out_of_range sample in frame
- busy  out  1  state != IDLE

## Operation
- States: IDLE, PRE, WAIT_TRIG, POST, DONE.
- IDLE: adc_en=0. Rising or held arm -> PRE. On entry to PRE: waddr=0, pre counter=0, prev_valid=0, ovr_flag=0, trig_auto=0.
- pretrig is latched at arm as P = min(pretrig, DEPTH-1). P=0 skips PRE and goes straight to WAIT_TRIG.
- PRE: write each valid sample and increment waddr (mod DEPTH). After P samples are written -> WAIT_TRIG.
- WAIT_TRIG: keep writing circularly. The trigger fires on a valid sample with prev_valid=1:
  - rising: prev < level and cur >= level
  - falling: prev > level and cur <= level
  - Compare is signed, full DATA_W.
- prev/prev_valid update on every valid sample in PRE and WAIT_TRIG.
- Auto timeout, mode 1 only:
  - The cycle counter resets on entry to WAIT_TRIG.
  - When the counter reaches AUTO_TIMEOUT, the next valid sample is the trigger sample and trig_auto=1.
  - A real trigger on that same sample wins, and trig_auto stays 0.
- Trigger sample handling: it is written. frame_start = (trigger waddr − P) mod DEPTH. Then -> POST with remaining = DEPTH−P−1.
- POST: write samples until remaining reaches 0, then -> DONE. If remaining=0 at entry (P=DEPTH−1), go directly to DONE.
- DONE: adc_en=0, done=1. On done_ack:
  - mode 2 -> IDLE
  - otherwise -> PRE (re-arm, same entry actions)
- The frame occupies exactly DEPTH addresses starting at frame_start.
- ovr_flag sets on any valid out_of_range sample in PRE, WAIT_TRIG or POST.
- abort (any state) -> IDLE next cycle. Outputs in IDLE: done=0, mem_we=0, frame_start/ovr_flag/trig_auto hold. abort has priority over all other events.
- arm outside IDLE, and done_ack outside DONE, are ignored.

## Timing
- Reset values: adc_en=0, mem_we=0, mem_waddr=0, mem_wdata=0, frame_start=0, done=0, trig_auto=0, ovr_flag=0, busy=0, state=IDLE.
- adc_en is registered: 1 in the cycle after entering PRE/WAIT_TRIG/POST; 0 in the cycle after entering DONE/IDLE.
- Write latency: sample_valid in cycle N -> mem_we=1 in N+1 for exactly one cycle, with mem_waddr/mem_wdata valid.
- Samples arriving in the cycle the state transitions to DONE or IDLE are not written.
- done rises in the cycle after the last write. done_ack in cycle M -> done=0 in M+1, and the new state takes effect in M+1.
- The trigger decision is made in the same cycle as the trigger sample's write request. frame_start is valid by the time done is asserted.
- sample_valid may be asserted every cycle (full rate).

## Test plan
- ADDR_W=4, P=4, normal, rising, level=0; ramp −20..+20 step 1, one per cycle -> PRE writes 4; trigger on sample 0; 11 more writes; done=1; frame_start = trigger addr − 4 mod 16; RAM holds −4..+11; trig_auto=0.
- Falling slope, level=100; sine ±500 -> trigger at the first sample ≤100 after a sample >100; a constant input at 100 never triggers.
- Auto mode, AUTO_TIMEOUT=50, constant input 0 with level=1000 -> forced trigger on the first valid sample after 50 cycles; trig_auto=1; frame completes.
- P=0 and P≥DEPTH (clamped to 15) -> the first WAIT_TRIG sample does not trigger (prev invalid); P=15 goes to DONE right after the trigger write.
- Mode 2 then mode 0: done_ack -> IDLE with adc_en=0 (single); in mode 0 -> re-armed PRE with ovr_flag cleared; out_of_range pulse mid-frame -> ovr_flag=1.
- abort during POST with sample_valid high -> IDLE next cycle, no further mem_we; rst_n low mid-capture -> all outputs at reset values immediately (asynchronous).
